// File: rtl/jtcontra_snd_pkg.sv
// Shared constants for the main-to-sound CPU command mailbox.
package jtcontra_snd_pkg;

  // Sound-CPU interrupt generation modes
  localparam int unsigned IRQ_LEVEL = 0;  // IRQ asserted while commands are queued
  localparam int unsigned IRQ_EDGE  = 1;  // IRQ flag set per push, cleared by ack

endpackage

// File: rtl/jtcontra_snd_fifo.sv
// Show-ahead command FIFO with registered head, level and full/empty flags.
module jtcontra_snd_fifo #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty,
  output logic          push_ok,
  output logic          ovf_evt
);

  localparam int unsigned DEPTH    = 2 ** AW;
  // A one-entry latch still needs a 1-bit pointer; it simply never leaves 0.
  localparam int unsigned PW       = (AW > 0) ? AW : 1;
  localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   level_q, level_d;
  logic          full_q, full_d, empty_q, empty_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          pop_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Accept/reject decisions and next-state for pointers, level, flags and head
  always_comb begin
    pop_ok  = pop && !empty_q;
    // A pop in the same cycle frees the slot a push into a full FIFO needs
    push_ok = push && (!full_q || pop_ok);
    ovf_evt = push && full_q && !pop_ok;

    wr_d = push_ok ? ptr_inc(wr_q) : wr_q;
    rd_d = pop_ok  ? ptr_inc(rd_q) : rd_q;

    level_d = level_q;
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    full_d  = (level_d == FULL_LVL);
    empty_d = (level_d == '0);

    // Head register tracks mem[rd_ptr]; bypass the write landing on the new head
    dout_d = dout_q;
    if (push_ok || pop_ok) begin
      dout_d = (push_ok && (wr_q == rd_d)) ? din : mem[rd_d];
    end
  end

  // Storage write port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push_ok) begin
      mem[wr_q] <= din;
    end
  end

  // Pointer, level, flag and head registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      dout_q  <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      dout_q  <= dout_d;
    end
  end

  assign dout  = dout_q;
  assign level = level_q;
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/jtcontra_snd_mailbox.sv
// Main-to-sound CPU mailbox: command FIFO, sound IRQ, reply latch and overflow flag.
module jtcontra_snd_mailbox
  import jtcontra_snd_pkg::*;
#(
  parameter int unsigned DW       = 8,
  parameter int unsigned AW       = 2,
  parameter int unsigned IRQ_MODE = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          main_wr,
  input  logic [DW-1:0] main_din,
  input  logic          main_rd,
  output logic [DW-1:0] main_dout,
  output logic          reply_pending,
  output logic          full,
  output logic          ovf,
  input  logic          ovf_clr,
  input  logic          snd_rd,
  output logic [DW-1:0] snd_dout,
  output logic          empty,
  output logic [AW:0]   level,
  input  logic          snd_irq_ack,
  output logic          snd_irq_n,
  input  logic          snd_wr,
  input  logic [DW-1:0] snd_din
);

  logic          push_ok, ovf_evt;
  logic          ovf_q, irq_q, pend_q;
  logic [DW-1:0] reply_q;

  jtcontra_snd_fifo #(
    .DW (DW),
    .AW (AW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (main_wr),
    .din     (main_din),
    .pop     (snd_rd),
    .dout    (snd_dout),
    .level   (level),
    .full    (full),
    .empty   (empty),
    .push_ok (push_ok),
    .ovf_evt (ovf_evt)
  );

  // Sticky overflow; a new overflow beats a simultaneous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          ovf_q <= 1'b0;
    else if (ovf_evt) ovf_q <= 1'b1;
    else if (ovf_clr) ovf_q <= 1'b0;
  end

  // Edge-mode IRQ flag; an accepted push beats a simultaneous ack
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              irq_q <= 1'b0;
    else if (push_ok)     irq_q <= 1'b1;
    else if (snd_irq_ack) irq_q <= 1'b0;
  end

  // Reply latch; a new reply beats a simultaneous main-CPU read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reply_q <= '0;
      pend_q  <= 1'b0;
    end else begin
      if (snd_wr) reply_q <= snd_din;
      if (snd_wr)       pend_q <= 1'b1;
      else if (main_rd) pend_q <= 1'b0;
    end
  end

  // Level mode reuses the registered empty flag directly
  assign snd_irq_n     = (IRQ_MODE == IRQ_EDGE) ? ~irq_q : empty;
  assign ovf           = ovf_q;
  assign main_dout     = reply_q;
  assign reply_pending = pend_q;

endmodule

// File: tb/tb_jtcontra_snd_mailbox.sv
// Self-checking bench: edge-mode and level-mode mailboxes driven in parallel.
module tb_jtcontra_snd_mailbox;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       main_wr = 1'b0, main_rd = 1'b0, ovf_clr = 1'b0, snd_rd = 1'b0;
  logic       snd_irq_ack = 1'b0, snd_wr = 1'b0;
  logic [7:0] main_din = 8'h00, snd_din = 8'h00;

  logic [7:0] main_dout, snd_dout, l_main_dout, l_snd_dout;
  logic       reply_pending, full, ovf, empty, snd_irq_n;
  logic       l_reply_pending, l_full, l_ovf, l_empty, l_snd_irq_n;
  logic [2:0] level, l_level;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] sb[$];

  always #5 clk = ~clk;

  jtcontra_snd_mailbox #(.DW(8), .AW(2), .IRQ_MODE(1)) dut (
    .clk (clk), .rst (rst), .main_wr (main_wr), .main_din (main_din), .main_rd (main_rd),
    .main_dout (main_dout), .reply_pending (reply_pending), .full (full), .ovf (ovf),
    .ovf_clr (ovf_clr), .snd_rd (snd_rd), .snd_dout (snd_dout), .empty (empty),
    .level (level), .snd_irq_ack (snd_irq_ack), .snd_irq_n (snd_irq_n), .snd_wr (snd_wr),
    .snd_din (snd_din)
  );

  jtcontra_snd_mailbox #(.DW(8), .AW(2), .IRQ_MODE(0)) dut_lvl (
    .clk (clk), .rst (rst), .main_wr (main_wr), .main_din (main_din), .main_rd (main_rd),
    .main_dout (l_main_dout), .reply_pending (l_reply_pending), .full (l_full), .ovf (l_ovf),
    .ovf_clr (ovf_clr), .snd_rd (snd_rd), .snd_dout (l_snd_dout), .empty (l_empty),
    .level (l_level), .snd_irq_ack (snd_irq_ack), .snd_irq_n (l_snd_irq_n), .snd_wr (snd_wr),
    .snd_din (snd_din)
  );

  // Advance one clock; outputs are then sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
    main_wr = 1'b0; main_rd = 1'b0; ovf_clr = 1'b0; snd_rd = 1'b0;
    snd_irq_ack = 1'b0; snd_wr = 1'b0;
  endtask

  // Drive push/pop strobes; the scoreboard predicts acceptance for a depth-4 FIFO
  task automatic step(input logic wr, input logic [7:0] d, input logic rd);
    logic [7:0] exp;
    if (rd && sb.size() > 0) begin
      exp = sb.pop_front();
      n_cmp++;
      if (snd_dout !== exp) begin
        n_err++; $display("FAIL sb_head got %h want %h", snd_dout, exp);
      end
      n_cmp++;
      if (l_snd_dout !== exp) begin
        n_err++; $display("FAIL sb_head_lvl got %h want %h", l_snd_dout, exp);
      end
    end
    if (wr && sb.size() < 4) sb.push_back(d);
    main_wr = wr; main_din = d; snd_rd = rd;
    tick();
  endtask

  task automatic test_reset();
    #12;
    n_cmp++;
    if ({snd_irq_n, snd_dout, main_dout, reply_pending, full, empty, ovf, level} !==
        {1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0}) begin
      n_err++; $display("FAIL reset_vals got irq_n=%b dout=%h rep=%h pend=%b full=%b empty=%b ovf=%b lvl=%0d want 1 00 00 0 0 1 0 0",
                        snd_irq_n, snd_dout, main_dout, reply_pending, full, empty, ovf, level);
    end
    n_cmp++;
    if (l_snd_irq_n !== 1'b1) begin
      n_err++; $display("FAIL reset_irq_lvl got %b want 1", l_snd_irq_n);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    step(1'b1, 8'h11, 1'b0);
    n_cmp++;
    if (snd_dout !== 8'h11 || empty !== 1'b0) begin
      n_err++; $display("FAIL basic_first got dout=%h empty=%b want 11 0", snd_dout, empty);
    end
    n_cmp++;
    if (snd_irq_n !== 1'b0 || l_snd_irq_n !== 1'b0) begin
      n_err++; $display("FAIL basic_irq got edge=%b lvl=%b want 0 0", snd_irq_n, l_snd_irq_n);
    end
    step(1'b1, 8'h22, 1'b0);
    step(1'b1, 8'h33, 1'b0);
    n_cmp++;
    if (level !== 3'd3) begin
      n_err++; $display("FAIL basic_level got %0d want 3", level);
    end
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    n_cmp++;
    if (l_snd_irq_n !== 1'b0) begin
      n_err++; $display("FAIL lvl_irq_early got %b want 0", l_snd_irq_n);
    end
    step(1'b0, 8'h00, 1'b1);
    n_cmp++;
    if (empty !== 1'b1 || level !== 3'd0 || l_snd_irq_n !== 1'b1) begin
      n_err++; $display("FAIL basic_drain got empty=%b lvl=%0d irq_lvl=%b want 1 0 1",
                        empty, level, l_snd_irq_n);
    end
    // Empty pop is ignored
    step(1'b0, 8'h00, 1'b1);
    n_cmp++;
    if (level !== 3'd0 || empty !== 1'b1) begin
      n_err++; $display("FAIL empty_pop got lvl=%0d empty=%b want 0 1", level, empty);
    end
    snd_irq_ack = 1'b1;
    tick();
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 4; i++) step(1'b1, 8'hA0 + 8'(i), 1'b0);
    n_cmp++;
    if (full !== 1'b1 || ovf !== 1'b0) begin
      n_err++; $display("FAIL ovf_full got full=%b ovf=%b want 1 0", full, ovf);
    end
    step(1'b1, 8'hA4, 1'b0);
    n_cmp++;
    if (ovf !== 1'b1 || level !== 3'd4) begin
      n_err++; $display("FAIL ovf_set got ovf=%b lvl=%0d want 1 4", ovf, level);
    end
    ovf_clr = 1'b1;
    tick();
    n_cmp++;
    if (ovf !== 1'b0) begin
      n_err++; $display("FAIL ovf_clr_full got %b want 0", ovf);
    end
    // Overflow coinciding with clear keeps the flag set
    ovf_clr = 1'b1;
    step(1'b1, 8'hA5, 1'b0);
    n_cmp++;
    if (ovf !== 1'b1) begin
      n_err++; $display("FAIL ovf_set_wins got %b want 1", ovf);
    end
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1);
    n_cmp++;
    if (ovf !== 1'b1 || empty !== 1'b1) begin
      n_err++; $display("FAIL ovf_sticky got ovf=%b empty=%b want 1 1", ovf, empty);
    end
    ovf_clr = 1'b1;
    tick();
    n_cmp++;
    if (ovf !== 1'b0) begin
      n_err++; $display("FAIL ovf_clr got %b want 0", ovf);
    end
    snd_irq_ack = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) step(1'b1, 8'hC0 + 8'(i), 1'b0);
    step(1'b1, 8'hB5, 1'b1);
    n_cmp++;
    if (ovf !== 1'b0 || level !== 3'd4 || full !== 1'b1) begin
      n_err++; $display("FAIL full_pushpop got ovf=%b lvl=%0d full=%b want 0 4 1", ovf, level, full);
    end
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1);
    n_cmp++;
    if (empty !== 1'b1) begin
      n_err++; $display("FAIL full_drain got empty=%b want 1", empty);
    end
    step(1'b1, 8'h5A, 1'b1);
    n_cmp++;
    if (level !== 3'd1 || snd_dout !== 8'h5A || empty !== 1'b0) begin
      n_err++; $display("FAIL empty_pushpop got lvl=%0d dout=%h empty=%b want 1 5a 0",
                        level, snd_dout, empty);
    end
    step(1'b0, 8'h00, 1'b1);
    snd_irq_ack = 1'b1;
    tick();
  endtask

  task automatic test_irq_edge();
    n_cmp++;
    if (snd_irq_n !== 1'b1) begin
      n_err++; $display("FAIL irq_idle got %b want 1", snd_irq_n);
    end
    step(1'b1, 8'h01, 1'b0);
    snd_irq_ack = 1'b1;
    step(1'b1, 8'h02, 1'b0);
    n_cmp++;
    if (snd_irq_n !== 1'b0) begin
      n_err++; $display("FAIL irq_set_wins got %b want 0", snd_irq_n);
    end
    snd_irq_ack = 1'b1;
    tick();
    n_cmp++;
    if (snd_irq_n !== 1'b1 || level !== 3'd2 || l_snd_irq_n !== 1'b0) begin
      n_err++; $display("FAIL irq_ack got edge=%b lvl=%0d irq_lvl=%b want 1 2 0",
                        snd_irq_n, level, l_snd_irq_n);
    end
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    n_cmp++;
    if (l_snd_irq_n !== 1'b1 || snd_irq_n !== 1'b1) begin
      n_err++; $display("FAIL irq_drain got edge=%b lvl=%b want 1 1", snd_irq_n, l_snd_irq_n);
    end
  endtask

  task automatic test_reply();
    snd_wr = 1'b1; snd_din = 8'h7E;
    tick();
    n_cmp++;
    if (main_dout !== 8'h7E || reply_pending !== 1'b1) begin
      n_err++; $display("FAIL reply_load got dout=%h pend=%b want 7e 1", main_dout, reply_pending);
    end
    main_rd = 1'b1; snd_wr = 1'b1; snd_din = 8'h7F;
    tick();
    n_cmp++;
    if (main_dout !== 8'h7F || reply_pending !== 1'b1) begin
      n_err++; $display("FAIL reply_set_wins got dout=%h pend=%b want 7f 1", main_dout, reply_pending);
    end
    main_rd = 1'b1;
    tick();
    n_cmp++;
    if (reply_pending !== 1'b0 || main_dout !== 8'h7F) begin
      n_err++; $display("FAIL reply_read got dout=%h pend=%b want 7f 0", main_dout, reply_pending);
    end
  endtask

  task automatic test_async_reset();
    step(1'b1, 8'hE1, 1'b0);
    step(1'b1, 8'hE2, 1'b0);
    snd_wr = 1'b1; snd_din = 8'h55; ovf_clr = 1'b0;
    step(1'b1, 8'hE3, 1'b0);
    n_cmp++;
    if (level !== 3'd3 || snd_irq_n !== 1'b0 || reply_pending !== 1'b1) begin
      n_err++; $display("FAIL pre_rst got lvl=%0d irq_n=%b pend=%b want 3 0 1",
                        level, snd_irq_n, reply_pending);
    end
    // Reset asserted and sampled between clock edges
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({snd_irq_n, snd_dout, main_dout, reply_pending, full, empty, ovf, level, l_snd_irq_n} !==
        {1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1}) begin
      n_err++; $display("FAIL async_rst got irq_n=%b dout=%h rep=%h pend=%b full=%b empty=%b ovf=%b lvl=%0d irq_lvl=%b",
                        snd_irq_n, snd_dout, main_dout, reply_pending, full, empty, ovf, level,
                        l_snd_irq_n);
    end
    sb.delete();
    #2;
    rst = 1'b0;
    tick();
    step(1'b1, 8'hD7, 1'b0);
    n_cmp++;
    if (snd_dout !== 8'hD7 || level !== 3'd1) begin
      n_err++; $display("FAIL post_rst_push got dout=%h lvl=%0d want d7 1", snd_dout, level);
    end
    step(1'b0, 8'h00, 1'b1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_back_to_back();
    test_irq_edge();
    test_reply();
    test_async_reset();
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++; $display("FAIL sb_leftover got %0d want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/jtcontra_snd_mailbox.md
# jtcontra_snd_mailbox

Parametrised command mailbox between the main CPU and the sound CPU, replacing the single sound latch plus edge-triggered IRQ flip-flop. Main-CPU command bytes queue in a FIFO of configurable width and depth. The sound CPU gets an interrupt in level or edge mode, and a reply latch carries status back to the main CPU. It sits between the main-CPU address decoder and the sound-CPU bus multiplexer.

## Interface
Parameters:
- DW, 8, command/reply data width
- AW, 2, FIFO address width; depth = 2**AW (AW=0 gives a one-entry latch)
- IRQ_MODE, 1, 0 = level (IRQ while FIFO non-empty), 1 = edge (set per accepted push, cleared by ack)

Ports:
- clk  in  1  system clock (24 MHz)
- rst  in  1  asynchronous, active-high reset
- main_wr  in  1  one-cycle push strobe
- main_din  in  DW  command byte
- main_rd  in  1  one-cycle strobe, main CPU reads reply
- main_dout  out  DW  reply latch
- reply_pending  out  1  reply written, not yet read
- full  out  1  FIFO full
- ovf  out  1  sticky overflow flag
- ovf_clr  in  1  clears ovf
- snd_rd  in  1  one-cycle pop strobe
- snd_dout  out  DW  FIFO head (show-ahead)
- empty  out  1  FIFO empty
- level  out  AW+1  entries stored
- snd_irq_ack  in  1  clears edge-mode IRQ
- snd_irq_n  out  1  IRQ to sound CPU, active low
- snd_wr  in  1  one-cycle reply strobe
- snd_din  in  DW  reply byte

## Operation
- Push is accepted when main_wr=1 and the FIFO is not full. The data goes to the tail and level increments.
- Push when full: data dropped, ovf set. If snd_rd is high in the same cycle, the pop frees the slot, the push is accepted and ovf is unchanged.
- Pop is accepted when snd_rd=1 and the FIFO is not empty. The head advances and level decrements.
- Pop when empty is ignored. snd_dout holds its last value.
- Push and pop in the same cycle, FIFO empty: only the push takes effect, so level becomes 1.
- Push and pop in the same cycle, FIFO non-empty and not full: both take effect, level unchanged.
- Pointers are AW bits wide and wrap modulo 2**AW. Full/empty are derived from level, never from pointer equality alone.
- snd_dout is always mem[rd_ptr], registered. It is 0 after reset until the first push.
- IRQ_MODE=0: snd_irq_n = registered empty. snd_irq_ack is ignored.
- IRQ_MODE=1: an irq flag is set by each accepted push and cleared by snd_irq_ack. Set wins when both occur in the same cycle. snd_irq_n = ~flag.
- Reply latch: snd_wr loads main_dout and sets reply_pending. main_rd clears reply_pending. Set wins when both occur in the same cycle.
- ovf stays set until ovf_clr or rst. An overflow in the same cycle as ovf_clr leaves ovf set.

## Timing
- Reset values: snd_irq_n=1, snd_dout=0, main_dout=0, reply_pending=0, full=0, empty=1, ovf=0, level=0, pointers=0.
- All outputs are registered, and all strobe effects are visible on the cycle after the strobe edge.
- Push on cycle N:
  - snd_dout valid on N+1 if the FIFO was empty.
  - empty=0 and level updated on N+1.
  - snd_irq_n low on N+1 (both modes).
- A pop on N updates snd_dout, level, empty and full on N+1.
- No combinational path from any input to any output.
- rst mid-operation flushes the FIFO, drops pending IRQ and reply, and returns all outputs to reset values asynchronously.
- Strobes are single-cycle. A strobe held high for k cycles counts as k events.

## Structure
- Package jtcontra_snd_pkg holds the IRQ_LEVEL=0 and IRQ_EDGE=1 constants.
- Sub-module jtcontra_snd_fifo holds the storage, pointers, level, full/empty and overflow detection, parametrised by DW and AW.
- The top level adds the IRQ flag, reply latch and ovf register.

## Test plan
- Reset, then push 0x11, 0x22, 0x33 with AW=2 → snd_dout=0x11 one cycle after the first push, level=3, snd_irq_n=0. Three pops return 0x11, 0x22, 0x33 in order, then empty=1.
- Push 5 bytes 0xA0..0xA4 into AW=2 → full=1 after the 4th push. The 5th push is dropped and ovf=1. Pops return 0xA0..0xA3. ovf_clr then gives ovf=0.
- FIFO full, push 0xB5 with simultaneous pop → 0xB5 accepted, ovf stays 0, level stays 4. FIFO empty, push 0x5A with simultaneous pop → level=1, snd_dout=0x5A.
- IRQ_MODE=1: push 0x01, then snd_irq_ack while 0x02 is pushed in the same cycle → snd_irq_n stays 0. A lone ack then gives snd_irq_n=1 while level=2. IRQ_MODE=0: snd_irq_n rises only after the last pop.
- snd_wr 0x7E → main_dout=0x7E and reply_pending=1 next cycle. main_rd together with snd_wr 0x7F → reply_pending=1, main_dout=0x7F. A lone main_rd then gives reply_pending=0.
- Assert rst with 3 entries queued and IRQ pending → all outputs reach reset values without a clock edge. The first push after reset appears at snd_dout with level=1.
